// File: rtl/tap_controller_if.sv
// JTAG TAP pin and DR-control bundle between a test driver (master) and the TAP controller (slave).
interface tap_controller_if;
    logic TMS;
    logic TDI;
    logic DR;
    logic sel;
    logic CaptureDR;
    logic ShiftDR;
    logic UpdateDR;
    logic Mode;
    logic TDO;
    logic TDO_en;

    modport master (
        output TMS, TDI, DR,
        input  sel, CaptureDR, ShiftDR, UpdateDR, Mode, TDO, TDO_en
    );

    modport slave (
        input  TMS, TDI, DR,
        output sel, CaptureDR, ShiftDR, UpdateDR, Mode, TDO, TDO_en
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with instruction register, DR-path control strobes and falling-edge TDO.
module tap_controller #(
    parameter int unsigned          IR_WIDTH = 2,
    parameter logic [IR_WIDTH-1:0]  EXTEST   = '0,
    parameter logic [IR_WIDTH-1:0]  SAMPLE   = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  BYPASS   = '1
) (
    input  logic              TCK,
    input  logic              TRST,
    tap_controller_if.slave   bus
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t            r_state;
    tap_state_t            w_next_state;
    logic [IR_WIDTH-1:0]   r_ir_shift;
    logic [IR_WIDTH-1:0]   r_ir_active;
    logic                  r_tdo;
    logic                  r_tdo_en;
    logic                  w_shift_ir;
    logic                  w_shift_dr;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Standard 16-state TMS walk
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TLR:     w_next_state = bus.TMS ? TLR    : RTI;
            RTI:     w_next_state = bus.TMS ? SEL_DR : RTI;
            SEL_DR:  w_next_state = bus.TMS ? SEL_IR : CAP_DR;
            CAP_DR:  w_next_state = bus.TMS ? EX1_DR : SH_DR;
            SH_DR:   w_next_state = bus.TMS ? EX1_DR : SH_DR;
            EX1_DR:  w_next_state = bus.TMS ? UPD_DR : PA_DR;
            PA_DR:   w_next_state = bus.TMS ? EX2_DR : PA_DR;
            EX2_DR:  w_next_state = bus.TMS ? UPD_DR : SH_DR;
            UPD_DR:  w_next_state = bus.TMS ? SEL_DR : RTI;
            SEL_IR:  w_next_state = bus.TMS ? TLR    : CAP_IR;
            CAP_IR:  w_next_state = bus.TMS ? EX1_IR : SH_IR;
            SH_IR:   w_next_state = bus.TMS ? EX1_IR : SH_IR;
            EX1_IR:  w_next_state = bus.TMS ? UPD_IR : PA_IR;
            PA_IR:   w_next_state = bus.TMS ? EX2_IR : PA_IR;
            EX2_IR:  w_next_state = bus.TMS ? UPD_IR : SH_IR;
            UPD_IR:  w_next_state = bus.TMS ? SEL_DR : RTI;
            default: w_next_state = TLR;
        endcase
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_shift <= '0;
        end else if (r_state == CAP_IR) begin
            r_ir_shift <= IR_CAPTURE;
        end else if (r_state == SH_IR) begin
            r_ir_shift <= {bus.TDI, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Synchronous entry into TLR resets the instruction exactly like TRST
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_active <= BYPASS;
        end else if (w_next_state == TLR) begin
            r_ir_active <= BYPASS;
        end else if (r_state == UPD_IR) begin
            r_ir_active <= r_ir_shift;
        end
    end

    assign w_shift_ir = (r_state == SH_IR);
    assign w_shift_dr = (r_state == SH_DR);

    // TDO holds its last value outside shift states
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= w_shift_ir | w_shift_dr;
            if (w_shift_ir) begin
                r_tdo <= r_ir_shift[0];
            end else if (w_shift_dr) begin
                r_tdo <= bus.DR;
            end
        end
    end

    assign bus.sel       = !((r_ir_active == EXTEST) || (r_ir_active == SAMPLE));
    assign bus.Mode      = (r_ir_active == EXTEST);
    assign bus.CaptureDR = (r_state == CAP_DR);
    assign bus.ShiftDR   = w_shift_dr;
    assign bus.UpdateDR  = (r_state == UPD_DR);
    assign bus.TDO       = r_tdo;
    assign bus.TDO_en    = r_tdo_en;

endmodule

// File: tb/tb_tap_controller.sv
// Directed vector bench for tap_controller: IR/DR scans, pause resume, TMS reset and async TRST.
module tb_tap_controller;

    logic TCK;
    logic TRST;

    tap_controller_if bus ();

    tap_controller #(.IR_WIDTH(2)) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus.slave)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       dr;
        logic [6:0] exp;   // {sel, CaptureDR, ShiftDR, UpdateDR, Mode, TDO, TDO_en}
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic logic [6:0] outs();
        return {bus.sel, bus.CaptureDR, bus.ShiftDR, bus.UpdateDR, bus.Mode, bus.TDO, bus.TDO_en};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b required %b (sel,cap,shift,upd,mode,tdo,en)", name, got, exp);
        end
    endtask

    task automatic add(input logic tms, input logic tdi, input logic dr, input logic [6:0] exp);
        vec_t v;
        v.tms = tms;
        v.tdi = tdi;
        v.dr  = dr;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge and one falling edge, settle
    task automatic step(input logic tms, input logic tdi, input logic dr);
        bus.TMS = tms;
        bus.TDI = tdi;
        bus.DR  = dr;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Load EXTEST via IR scan (captured 01 shifts out first)
        add(0,0,0,7'b1000000); add(1,0,0,7'b1000000); add(1,0,0,7'b1000000); add(0,0,0,7'b1000000);
        add(0,0,0,7'b1000011); add(0,0,0,7'b1000001); add(1,0,0,7'b1000000); add(1,0,0,7'b1000000);
        add(0,0,0,7'b0000100);
        // DR scan of 1,0,1,1 under EXTEST
        add(1,0,0,7'b0000100); add(0,0,0,7'b0100100); add(0,0,1,7'b0010111); add(0,0,0,7'b0010101);
        add(0,0,1,7'b0010111); add(0,0,1,7'b0010111); add(1,0,0,7'b0000110); add(1,0,0,7'b0001110);
        add(0,0,0,7'b0000110);
        // Load SAMPLE through Exit1/Pause x3/Exit2/Shift
        add(1,0,0,7'b0000110); add(1,0,0,7'b0000110); add(0,0,0,7'b0000110); add(0,0,0,7'b0000111);
        add(1,1,0,7'b0000110); add(0,0,0,7'b0000110); add(0,0,0,7'b0000110); add(0,0,0,7'b0000110);
        add(1,0,0,7'b0000110); add(0,0,0,7'b0000101); add(1,0,0,7'b0000100); add(1,0,0,7'b0000100);
        add(0,0,0,7'b0000000);
        // Load undefined 10, decodes as bypass; exit Update-IR straight to Select-DR
        add(1,0,0,7'b0000000); add(1,0,0,7'b0000000); add(0,0,0,7'b0000000); add(0,0,0,7'b0000011);
        add(0,0,0,7'b0000001); add(1,1,0,7'b0000000); add(1,0,0,7'b0000000); add(1,0,0,7'b1000000);
        // Bypass DR shift, then five TMS=1 edges to TLR
        add(0,0,0,7'b1100000); add(0,0,1,7'b1010011); add(1,0,0,7'b1000010); add(1,0,0,7'b1001010);
        add(1,0,0,7'b1000010); add(1,0,0,7'b1000010); add(1,0,0,7'b1000010);
        // Reload EXTEST, enter Shift-DR, five TMS=1 edges must restore bypass decode
        add(0,0,0,7'b1000010); add(1,0,0,7'b1000010); add(1,0,0,7'b1000010); add(0,0,0,7'b1000010);
        add(0,0,0,7'b1000011); add(0,0,0,7'b1000001); add(1,0,0,7'b1000000); add(1,0,0,7'b1000000);
        add(1,0,0,7'b0000100); add(0,0,0,7'b0100100); add(0,0,0,7'b0010101); add(1,0,0,7'b0000100);
        add(1,0,0,7'b0001100); add(1,0,0,7'b0000100); add(1,0,0,7'b0000100); add(1,0,0,7'b1000000);
        add(1,0,0,7'b1000000);

        TRST    = 1'b1;
        bus.TMS = 1'b1;
        bus.TDI = 1'b0;
        bus.DR  = 1'b0;
        repeat (2) @(posedge TCK);
        @(negedge TCK);
        #1;
        check("reset", outs(), 7'b1000000);
        TRST = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].tms, vecs[i].tdi, vecs[i].dr);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Load EXTEST again from TLR
        step(0,0,0); step(1,0,0); step(1,0,0); step(0,0,0); step(0,0,0);
        step(0,0,0); step(1,0,0); step(1,0,0); step(0,0,0);
        check("extest_reload", outs(), 7'b0000100);

        // Enter Shift-IR and abort with TRST between clock edges
        step(1,0,0); step(1,0,0); step(0,0,0); step(0,0,0);
        check("mid_shift_ir", outs(), 7'b0000111);
        #2 TRST = 1'b1;
        #1;
        check("async_trst", outs(), 7'b1000000);
        @(negedge TCK);
        #1;
        check("trst_held", outs(), 7'b1000000);
        bus.TMS = 1'b0;
        TRST    = 1'b0;
        step(0,0,0);
        check("after_release_rti", outs(), 7'b1000000);

        // Fresh IR scan after abort still captures 01
        step(1,0,0); step(1,0,0); step(0,0,0); step(0,0,0);
        check("post_abort_capture", outs(), 7'b1000011);
        step(1,1,0); step(1,0,0); step(0,0,0);
        check("post_abort_bypass", outs(), 7'b1000010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
IEEE 1149.1 TAP controller and instruction register for the ripple-adder JTAG chain. It tracks TMS through the 16-state TAP FSM, shifts and decodes the instruction register, and drives the control side of the DR path. Control outputs are the DR select into the BSC/bypass DR mux, plus Capture/Shift/Update strobes. It receives the muxed DR bit back and drives TDO.

Parameters:
IR_WIDTH, 2, instruction register width (>=2)
EXTEST, 2'b00, opcode: boundary-scan chain selected, boundary cells drive pins
SAMPLE, 2'b01, opcode: boundary-scan chain selected, pins unaffected
BYPASS, 2'b11, opcode: bypass register selected; any undefined opcode decodes as BYPASS

Ports:
TCK  input  1  test clock; the only clock
TRST  input  1  asynchronous active-high reset
TMS  input  1  test mode select, sampled on rising TCK
TDI  input  1  serial data in, shifted into IR in Shift-IR
DR  input  1  serial bit from the DR mux (BSC chain or bypass)
sel  output  1  DR mux select: 0 = BSC chain, 1 = bypass register
CaptureDR  output  1  high while state = Capture-DR
ShiftDR  output  1  high while state = Shift-DR
UpdateDR  output  1  high while state = Update-DR
Mode  output  1  high when the active instruction is EXTEST (BSC output mux drives pins)
TDO  output  1  serial data out, retimed on falling TCK
TDO_en  output  1  TDO valid/enable, retimed on falling TCK

Behaviour:
- Reset (TRST=1, asynchronous):
  - state = Test-Logic-Reset; IR shift register = 0; active IR = BYPASS.
  - sel=1, Mode=0, CaptureDR=ShiftDR=UpdateDR=0, TDO=0, TDO_en=0.
  - Deassertion is sampled by the next rising TCK.
- FSM: 16 standard states, transitions on rising TCK from TMS exactly per 1149.1.
  - TLR: TMS=0 -> RTI. RTI: TMS=1 -> Select-DR.
  - Select-DR: TMS=1 -> Select-IR, TMS=0 -> Capture-DR. Select-IR: TMS=1 -> TLR, TMS=0 -> Capture-IR.
  - Capture-x: TMS=0 -> Shift-x, TMS=1 -> Exit1-x. Shift-x holds while TMS=0, TMS=1 -> Exit1-x.
  - Exit1-x: TMS=0 -> Pause-x, TMS=1 -> Update-x. Pause-x holds while TMS=0, TMS=1 -> Exit2-x.
  - Exit2-x: TMS=0 -> Shift-x, TMS=1 -> Update-x. Update-x: TMS=0 -> RTI, TMS=1 -> Select-DR.
  - Five consecutive rising edges with TMS=1 reach TLR from any state.
- Entering TLR synchronously (via TMS) has the same effect as TRST: active IR = BYPASS, Mode=0.
- IR shift register, rising TCK:
  - In Capture-IR it loads {IR_WIDTH-2 zeros, 2'b01} (LSBs 01 per standard).
  - In Shift-IR it shifts right: TDI enters the MSB, the LSB is presented to TDO.
- Active IR loads the shift register contents on the rising edge taken while state = Update-IR. The new decode is visible in the following cycle.
- Active IR is unchanged by DR scans, Pause, or Exit states.
- Decode (combinational from active IR):
  - sel = 0 for EXTEST/SAMPLE, 1 otherwise.
  - Mode = 1 only for EXTEST.
- DR strobes are combinational state decodes with no extra latency. The DR chain acts on the rising edge during which the strobe is high.
- TDO path: the falling-TCK register samples (Shift-IR ? IR[0] : DR).
  - TDO_en is registered on falling TCK as (state == Shift-IR or Shift-DR).
  - Outside shift states, TDO holds its last value and TDO_en=0.
- TRST asserted mid-scan aborts immediately: partial IR contents are discarded and active IR = BYPASS.

Test Plan:
- Pulse TRST with TMS=1 -> state=TLR, sel=1, Mode=0, TDO_en=0. Then 5 TCKs at TMS=1 from Shift-DR -> TLR.
- IR scan TMS 0,1,1,0,0 then shift TDI=0,0 (last bit with TMS=1), then Update-IR -> first two TDO bits during Shift-IR = 1,0 (captured 01). After Update-IR, Mode=1, sel=0 (EXTEST).
- Load SAMPLE (01) -> sel=0, Mode=0. Load undefined or BYPASS (10/11) -> sel=1, Mode=0.
- DR scan with DR input pattern 1,0,1,1 -> CaptureDR high for exactly one cycle. ShiftDR high for 4 cycles. TDO after each falling edge = 1,0,1,1 with TDO_en=1. UpdateDR high for one cycle. Active IR unchanged.
- Shift-IR -> Exit1-IR -> Pause-IR (3 cycles) -> Exit2-IR -> Shift-IR -> shift continues without loss. Active IR changes only after Update-IR.
- Assert TRST asynchronously mid Shift-IR (between edges) -> outputs reset immediately without a TCK edge. Active IR = BYPASS after release.
